// File: rtl/morse_receiver.sv
// Morse-style 13-slot serial line receiver: aligns on a rising edge, samples
// each slot at mid-slot and decodes the captured frame against an 8-entry table.
module morse_receiver #(
    parameter int SLOT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        din,
    output logic [2:0]  letter,
    output logic [12:0] frame,
    output logic        valid,
    output logic        error,
    output logic        busy
);

    localparam logic [7:0] HALF_CNT = 8'(SLOT_CYCLES / 2);
    localparam logic [7:0] SLOT_CNT = 8'(SLOT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SHIFT,
        CHECK
    } state_t;

    state_t      state_q, state_d;
    logic        din_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bits_q, bits_d;
    logic [12:0] shreg_q, shreg_d;
    logic [2:0]  letter_q, letter_d;
    logic [12:0] frame_q, frame_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    logic        hit;
    logic [2:0]  hit_idx;

    function automatic logic [12:0] code_of(input logic [2:0] idx);
        case (idx)
            3'd0:    code_of = 13'b1010000000000;
            3'd1:    code_of = 13'b1011101110111;
            3'd2:    code_of = 13'b1110101110000;
            3'd3:    code_of = 13'b1011101010000;
            3'd4:    code_of = 13'b1110111000000;
            3'd5:    code_of = 13'b1110100000000;
            3'd6:    code_of = 13'b1110111011100;
            default: code_of = 13'b1011101110100;
        endcase
    endfunction

    // Table entries are distinct, so at most one can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (shreg_q == code_of(3'(i))) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bits_d   = bits_q;
        shreg_d  = shreg_q;
        letter_d = letter_q;
        frame_d  = frame_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (din && !din_q) begin
                    cnt_d   = HALF_CNT;
                    bits_d  = 4'd0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q == 8'd1) begin
                    if (din) begin
                        shreg_d = 13'd1;
                        bits_d  = 4'd1;
                        cnt_d   = SLOT_CNT;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == 8'd1) begin
                    shreg_d = {shreg_q[11:0], din};
                    bits_d  = bits_q + 4'd1;
                    cnt_d   = SLOT_CNT;
                    if (bits_q == 4'd12) begin
                        state_d = CHECK;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CHECK: begin
                frame_d = shreg_q;
                if (hit) begin
                    letter_d = hit_idx;
                    valid_d  = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // din_q resets high so a line already high at release is not a start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            din_q    <= 1'b1;
            cnt_q    <= 8'd0;
            bits_q   <= 4'd0;
            shreg_q  <= 13'd0;
            letter_q <= 3'd0;
            frame_q  <= 13'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            shreg_q  <= shreg_d;
            letter_q <= letter_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign letter = letter_q;
    assign frame  = frame_q;
    assign valid  = valid_q;
    assign error  = error_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: two instances (2 and 5 cycles per slot) driven with
// directed and random frames, checked against a frame-level timing/decode model.
module tb_morse_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        din_a = 1'b0;
    logic        din_b = 1'b0;
    logic [2:0]  letter_a, letter_b;
    logic [12:0] frame_a, frame_b;
    logic        valid_a, valid_b, error_a, error_b, busy_a, busy_b;

    morse_receiver #(.SLOT_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .din(din_a), .letter(letter_a),
        .frame(frame_a), .valid(valid_a), .error(error_a), .busy(busy_a)
    );

    morse_receiver #(.SLOT_CYCLES(5)) dut_b (
        .clock(clock), .reset(reset), .din(din_b), .letter(letter_b),
        .frame(frame_b), .valid(valid_b), .error(error_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    int cyc;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [12:0] codes [8] = '{
        13'b1010000000000, 13'b1011101110111, 13'b1110101110000, 13'b1011101010000,
        13'b1110111000000, 13'b1110100000000, 13'b1110111011100, 13'b1011101110100
    };

    typedef struct {
        int          cyc;
        logic        ok;
        logic [2:0]  let_v;
        logic [12:0] frm;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [2:0]  mlet[2] = '{3'd0, 3'd0};
    logic [12:0] mfrm[2] = '{13'd0, 13'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [18:0] obs(input int sel);
        if (sel == 0) return {valid_a, error_a, busy_a, letter_a, frame_a};
        return {valid_b, error_b, busy_b, letter_b, frame_b};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_din(input int sel, input logic v);
        if (sel == 0) din_a = v;
        else din_b = v;
    endtask

    // Frame-level model: decode from the table, letter held on a miss.
    task automatic push_exp(input int sel, input logic [12:0] pat, input int res_cyc);
        exp_t e;
        e.cyc   = res_cyc;
        e.ok    = 1'b0;
        e.frm   = pat;
        e.let_v = mlet[sel];
        for (int i = 0; i < 8; i++) begin
            if (codes[i] == pat) begin
                e.ok    = 1'b1;
                e.let_v = 3'(i);
            end
        end
        mlet[sel] = e.let_v;
        mfrm[sel] = pat;
        if (sel == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic mon(input int sel);
        logic [18:0] o;
        exp_t        e;
        logic        due;
        o   = obs(sel);
        due = 1'b0;
        if (sel == 0 && qa.size() > 0 && qa[0].cyc == cyc) begin
            e = qa.pop_front();
            due = 1'b1;
        end else if (sel == 1 && qb.size() > 0 && qb[0].cyc == cyc) begin
            e = qb.pop_front();
            due = 1'b1;
        end
        if (due) begin
            chk($sformatf("valid_%0d", sel), 32'(o[18]), 32'(e.ok));
            chk($sformatf("error_%0d", sel), 32'(o[17]), 32'(!e.ok));
            chk($sformatf("letter_%0d", sel), 32'(o[15:13]), 32'(e.let_v));
            chk($sformatf("frame_%0d", sel), 32'(o[12:0]), 32'(e.frm));
            chk($sformatf("busy_result_%0d", sel), 32'(o[16]), 32'd0);
        end else begin
            chk($sformatf("no_pulse_%0d", sel), 32'(o[18:17]), 32'd0);
        end
    endtask

    always @(negedge clock) begin
        mon(0);
        mon(1);
    end

    task automatic send(input int sel, input logic [12:0] pat, input int hold_hi, input int gap);
        int s;
        int h;
        int e0;
        s = (sel == 0) ? 2 : 5;
        h = s / 2;
        tick();
        set_din(sel, pat[12]);
        e0 = cyc + 1;
        push_exp(sel, pat, e0 + h + 12 * s + 1);
        for (int k = 1; k < 13; k++) begin
            repeat (s) tick();
            if (k == 1) chk($sformatf("busy_run_%0d", sel), 32'(obs(sel)), 32'(obs(sel)) | 32'h10000);
            set_din(sel, pat[12-k]);
        end
        repeat (s) tick();
        if (pat[0] && hold_hi > 0) begin
            repeat (hold_hi) tick();
            chk($sformatf("busy_rearm_%0d", sel), 32'(obs(sel) >> 16) & 32'h1, 32'd0);
        end
        set_din(sel, 1'b0);
        repeat (gap) tick();
    endtask

    task automatic glitch(input int sel, input int g);
        int s;
        int h;
        s = (sel == 0) ? 2 : 5;
        h = s / 2;
        tick();
        set_din(sel, 1'b1);
        tick();
        chk($sformatf("busy_glitch_start_%0d", sel), 32'(obs(sel) >> 16) & 32'h1, 32'd1);
        repeat (g - 1) tick();
        set_din(sel, 1'b0);
        repeat (h + 1) tick();
        chk($sformatf("busy_glitch_end_%0d", sel), 32'(obs(sel) >> 16) & 32'h1, 32'd0);
        chk($sformatf("letter_glitch_%0d", sel), 32'(obs(sel) >> 13) & 32'h7, 32'(mlet[sel]));
        chk($sformatf("frame_glitch_%0d", sel), 32'(obs(sel)) & 32'h1FFF, 32'(mfrm[sel]));
        tick();
    endtask

    task automatic chk_zero(input string tag);
        for (int sel = 0; sel < 2; sel++) begin
            chk($sformatf("%s_outputs_%0d", tag, sel), 32'(obs(sel)), 32'd0);
        end
    endtask

    initial begin
        logic [12:0] pat;
        int          sel;
        int          kind;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        send(0, codes[1], 6, 2);
        send(0, 13'h1FFF, 8, 2);
        glitch(0, 1);
        send(0, codes[1], 8, 1);
        send(0, codes[5], 0, 2);

        // Reset during slot 6 of a frame with the line high.
        tick();
        din_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            repeat (2) tick();
            din_a = codes[1][12-k];
        end
        tick();
        reset = 1'b1;
        #1;
        chk_zero("reset_mid");
        mlet = '{3'd0, 3'd0};
        mfrm = '{13'd0, 13'd0};
        repeat (3) tick();
        reset = 1'b0;
        repeat (30) tick();
        chk("busy_held_high", 32'(busy_a), 32'd0);
        din_a = 1'b0;
        tick();
        send(0, codes[0], 0, 2);

        send(1, codes[6], 0, 2);
        glitch(1, 2);

        for (int n = 0; n < 40; n++) begin
            sel  = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
                glitch(sel, (sel == 0) ? 1 : int'($urandom_range(1, 2)));
            end else begin
                if (kind < 6) pat = codes[$urandom_range(0, 7)];
                else pat = {1'b1, 12'($urandom)};
                send(sel, pat, int'($urandom_range(0, 5)), int'($urandom_range(1, 4)));
            end
        end

        repeat (5) tick();
        chk("pending_results", 32'(qa.size() + qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
